// File: rtl/dmem_access.sv
// Data-memory access unit: turns EX load/store control into single-beat req/ack
// bus transactions, stalls the pipeline while busy, and aligns/extends load data.
module dmem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [31:0] mem_out,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic r;
    case (size)
      2'b00:   r = 1'b0;
      2'b01:   r = lane[0];
      default: r = (lane != 2'b00);
    endcase
    return r;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] r;
    case (size)
      2'b00:   r = 4'b0001 << lane;
      2'b01:   r = lane[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] load_data(input logic [1:0] size, input logic [1:0] lane,
                                            input logic sgn, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   r = sgn ? {{24{b[7]}}, b} : {24'd0, b};
      2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  state_t      state_q;
  logic        bus_req_q, bus_we_q, misalign_q, bus_err_q, sign_q;
  logic [31:0] bus_addr_q, bus_wdata_q, mem_out_q;
  logic [3:0]  bus_be_q;
  logic [1:0]  lane_q, size_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        access_s, misalign_s, start_s;

  // Access detection, stall generation and timeout counter next value.
  always_comb begin
    access_s   = ex_valid & (mem_rd | mem_wr);
    misalign_s = is_misaligned(mem_size, addr[1:0]);
    start_s    = (state_q == ST_IDLE) & access_s & ~misalign_s;
    stall      = start_s | (state_q == ST_BUSY);
    cnt_d      = cnt_q + 8'd1;
  end

  // Transaction FSM with registered bus and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_be_q    <= 4'd0;
      mem_out_q   <= 32'd0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      cnt_q       <= 8'd0;
      lane_q      <= 2'd0;
      size_q      <= 2'd0;
      sign_q      <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (access_s && misalign_s) begin
            misalign_q <= 1'b1;
          end else if (access_s) begin
            state_q     <= ST_BUSY;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_wr;
            bus_addr_q  <= {addr[31:2], 2'b00};
            bus_wdata_q <= store_data(mem_size, wr_data);
            bus_be_q    <= byte_en(mem_size, addr[1:0]);
            lane_q      <= addr[1:0];
            size_q      <= mem_size;
            sign_q      <= mem_signed;
            cnt_q       <= 8'd0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_d;
          // Ack takes priority over a timeout expiring in the same cycle.
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            state_q   <= ST_DONE;
            if (!bus_we_q) begin
              mem_out_q <= load_data(size_q, lane_q, sign_q, bus_rdata);
            end else begin
              mem_out_q <= mem_out_q;
            end
          end else if (cnt_d == TIMEOUT_LIM) begin
            bus_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            mem_out_q <= 32'd0;
            state_q   <= ST_DONE;
          end else begin
            state_q <= ST_BUSY;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign bus_be       = bus_be_q;
  assign mem_out      = mem_out_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;

endmodule
